// File: rtl/testmasterslave8_master_pkg.sv
// ============================================================================
// Module   : testmasterslave8_types (package)
// Purpose  : Shared types and constants for the TestMasterSlave8 master driver.
//            Holds the driver FSM state encoding and the sent-count ceiling.
// Config   : MS8_MASTER_READY_EN (consumed by the interface and top, not here)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package testmasterslave8_types;

    // Driver FSM sections
    typedef enum logic [1:0] {
        DRV_IDLE = 2'd0,
        DRV_EMIT = 2'd1,
        DRV_GAP  = 2'd2
    } drv_sections_t;

    // Saturation ceiling of the completed-transfer counter
    localparam logic [15:0] SENT_MAX = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/testmasterslave8_master_if.sv
// ============================================================================
// Module   : testmasterslave8_master_if
// Purpose  : Slave-in channel between the TestMasterSlave8 master and slave.
//            m_out      - 32-bit data word (to slave s_in)
//            m_out_sync - one-cycle data-valid strobe (to slave s_in_sync)
//            m_out_ready- slave acceptance (only with MS8_MASTER_READY_EN)
// Config   : MS8_MASTER_READY_EN adds the m_out_ready back-pressure signal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface testmasterslave8_master_if;

    logic [31:0] m_out;
    logic        m_out_sync;

`ifdef MS8_MASTER_READY_EN
    logic        m_out_ready;

    modport master (output m_out, output m_out_sync, input  m_out_ready);
    modport slave  (input  m_out, input  m_out_sync, output m_out_ready);
`else
    modport master (output m_out, output m_out_sync);
    modport slave  (input  m_out, input  m_out_sync);
`endif

endinterface

`default_nettype wire

// File: rtl/testmasterslave8_master_gap_counter.sv
// ============================================================================
// Module   : ms8_gap_counter
// Purpose  : 8-bit inter-transfer gap counter with load, decrement and a
//            zero flag. Decrement stops at zero.
// Ports    : clk, rst (async, active-high)
//            i_load     - load i_load_val (has priority over decrement)
//            i_load_val - value to load
//            i_dec      - decrement by one when non-zero
//            o_zero     - counter is zero
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ms8_gap_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_zero = (r_cnt == 8'd0);

endmodule

`default_nettype wire

// File: rtl/testmasterslave8_master.sv
// ============================================================================
// Module   : testmasterslave8_master
// Purpose  : Master-side driver for the TestMasterSlave8 slave-in channel.
//            Emits START, START+STEP, ... on m_out, each qualified by an
//            m_out_sync strobe, with GAP_CYCLES idle cycles between strobes
//            while enable is held.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            enable     - run request, sampled every cycle
//            bus        - master modport: m_out, m_out_sync (m_out_ready)
//            busy       - FSM is not idle
//            sent_count - completed transfers, saturating at 16'hFFFF
// Config   : MS8_MASTER_READY_EN - hold each strobe until m_out_ready is
//            sampled high; without it every strobe lasts one cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module testmasterslave8_master
    import testmasterslave8_types::*;
#(
    parameter int START      = 0,
    parameter int STEP       = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    testmasterslave8_master_if.master  bus,
    output logic                       busy,
    output logic [15:0]                sent_count
);

    localparam logic [31:0] c_start    = 32'(START);
    localparam logic [31:0] c_step     = 32'(STEP);
    localparam logic        c_has_gap  = (GAP_CYCLES > 0);
    // The counter runs GAP_CYCLES-1 .. 0, one gap cycle per count value.
    localparam logic [7:0]  c_gap_load = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    drv_sections_t r_state;
    drv_sections_t w_state_next;
    logic [31:0]   r_val;
    logic [31:0]   w_val_next;
    logic [31:0]   r_m_out;
    logic          r_m_out_sync;
    logic          r_busy;
    logic [15:0]   r_sent_count;
    logic          w_ready;
    logic          w_complete;
    logic          w_gap_load;
    logic          w_gap_dec;
    logic          w_gap_zero;

`ifdef MS8_MASTER_READY_EN
    assign w_ready = bus.m_out_ready;
`else
    assign w_ready = 1'b1;
`endif

    // A transfer completes on the last cycle of DRV_EMIT.
    assign w_complete = (r_state == DRV_EMIT) && w_ready;
    assign w_val_next = w_complete ? (r_val + c_step) : r_val;

    ms8_gap_counter u_gap_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_gap_load),
        .i_load_val (c_gap_load),
        .i_dec      (w_gap_dec),
        .o_zero     (w_gap_zero)
    );

    always_comb begin
        w_state_next = r_state;
        w_gap_load   = 1'b0;
        w_gap_dec    = 1'b0;
        case (r_state)
            DRV_IDLE: begin
                if (enable) w_state_next = DRV_EMIT;
            end
            DRV_EMIT: begin
                if (w_complete) begin
                    if (c_has_gap) begin
                        w_state_next = DRV_GAP;
                        w_gap_load   = 1'b1;
                    end else begin
                        w_state_next = enable ? DRV_EMIT : DRV_IDLE;
                    end
                end
            end
            DRV_GAP: begin
                // enable only matters once the gap has fully elapsed
                if (w_gap_zero) begin
                    w_state_next = enable ? DRV_EMIT : DRV_IDLE;
                end else begin
                    w_gap_dec = 1'b1;
                end
            end
            default: w_state_next = DRV_IDLE;
        endcase
    end

    // Outputs are registered from the next state so that m_out_sync is high
    // exactly during DRV_EMIT and m_out already carries the value to send.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= DRV_IDLE;
            r_val        <= c_start;
            r_m_out      <= 32'd0;
            r_m_out_sync <= 1'b0;
            r_busy       <= 1'b0;
            r_sent_count <= 16'd0;
        end else begin
            r_state      <= w_state_next;
            r_val        <= w_val_next;
            r_m_out_sync <= (w_state_next == DRV_EMIT);
            r_busy       <= (w_state_next != DRV_IDLE);
            if (w_state_next == DRV_EMIT) begin
                r_m_out <= w_val_next;
            end
            if (w_complete && (r_sent_count != SENT_MAX)) begin
                r_sent_count <= r_sent_count + 16'd1;
            end
        end
    end

    assign bus.m_out      = r_m_out;
    assign bus.m_out_sync = r_m_out_sync;
    assign busy           = r_busy;
    assign sent_count     = r_sent_count;

endmodule

`default_nettype wire

// File: tb/tb_testmasterslave8_master.sv
// ============================================================================
// Module   : tb_testmasterslave8_master
// Purpose  : Self-checking bench for testmasterslave8_master. A default
//            instance (START=0, STEP=1, GAP_CYCLES=2) is checked every cycle
//            against a transfer-level reference model; a second instance
//            (START=32'h7FFFFFFF, GAP_CYCLES=0) covers the wrap case.
// Config   : MS8_MASTER_READY_EN - also exercises m_out_ready back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_testmasterslave8_master;

    localparam int START = 0;
    localparam int STEP  = 1;
    localparam int GAP   = 2;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        enable  = 1'b0;
    logic        enable2 = 1'b0;
    logic        busy, busy2;
    logic [15:0] cnt, cnt2;

    int n_cmp = 0;
    int n_err = 0;

    testmasterslave8_master_if bus1 ();
    testmasterslave8_master_if bus2 ();

    always #5 clk = ~clk;

    testmasterslave8_master #(.START(START), .STEP(STEP), .GAP_CYCLES(GAP)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bus        (bus1),
        .busy       (busy),
        .sent_count (cnt)
    );

    testmasterslave8_master #(.START(32'h7FFFFFFF), .STEP(1), .GAP_CYCLES(0)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable2),
        .bus        (bus2),
        .busy       (busy2),
        .sent_count (cnt2)
    );

    // ---------------------------------------------------------------- checker
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------------------------------------------------- reference model
    // Transfer-level view: are we strobing, how many gap cycles remain, the
    // next value to send, the last value sent and the completed-transfer count.
    logic        m_emit;
    int          m_gap_left;
    logic [31:0] m_val;
    logic [31:0] m_out;
    int          m_cnt;

    task automatic model_reset();
        m_emit     = 1'b0;
        m_gap_left = 0;
        m_val      = 32'(START);
        m_out      = 32'd0;
        m_cnt      = 0;
    endtask

    // Advance the model across one rising edge with the sampled inputs.
    task automatic model_step(input logic en, input logic rdy);
        logic done;
`ifdef MS8_MASTER_READY_EN
        done = rdy;
`else
        done = 1'b1;
`endif
        if (m_emit) begin
            if (done) begin
                m_val = m_val + 32'(STEP);
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (GAP > 0) begin
                    m_emit     = 1'b0;
                    m_gap_left = GAP;
                end else begin
                    m_emit = en;
                end
            end
        end else if (m_gap_left > 0) begin
            m_gap_left = m_gap_left - 1;
            if (m_gap_left == 0) m_emit = en;
        end else begin
            m_emit = en;
        end
        if (m_emit) m_out = m_val;
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".sync"}, 32'(bus1.m_out_sync), 32'(m_emit));
        check_val({tag, ".out"},  bus1.m_out, m_out);
        check_val({tag, ".busy"}, 32'(busy), 32'(m_emit || (m_gap_left > 0)));
        check_val({tag, ".cnt"},  32'(cnt), 32'(m_cnt));
    endtask

    // Drive inputs at the falling edge, cross one rising edge, check at the
    // next falling edge.
    task automatic tick(input string tag, input logic en, input logic rdy);
        enable = en;
`ifdef MS8_MASTER_READY_EN
        bus1.m_out_ready = rdy;
`endif
        @(posedge clk);
        model_step(en, rdy);
        @(negedge clk);
        check_all(tag);
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
`ifdef MS8_MASTER_READY_EN
        bus1.m_out_ready = 1'b1;
        bus2.m_out_ready = 1'b1;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        check_val("reset2.sync", 32'(bus2.m_out_sync), 32'd0);
        check_val("reset2.out",  bus2.m_out, 32'd0);
        check_val("reset2.busy", 32'(busy2), 32'd0);
        check_val("reset2.cnt",  32'(cnt2), 32'd0);
        rst = 1'b0;

        // enable held from cycle 0: strobes in cycles 1, 4, 7
        for (int i = 0; i < 8; i++) tick("run", 1'b1, 1'b1);
        check_val("cnt_after_3", 32'(cnt), 32'd3);

        // async reset while a strobe is high
        for (int i = 0; i < 5 && !m_emit; i++) tick("to_emit", 1'b1, 1'b1);
        check_val("pre_rst.sync", 32'(bus1.m_out_sync), 32'd1);
        rst = 1'b1;
        #1;
        check_val("rst_mid.sync", 32'(bus1.m_out_sync), 32'd0);
        check_val("rst_mid.out",  bus1.m_out, 32'd0);
        check_val("rst_mid.busy", 32'(busy), 32'd0);
        check_val("rst_mid.cnt",  32'(cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // enable dropped in the first gap cycle: gap completes, then idle
        tick("drop", 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) tick("drop", 1'b0, 1'b1);
        check_val("drop_idle.busy", 32'(busy), 32'd0);
        check_val("drop_idle.sync", 32'(bus1.m_out_sync), 32'd0);
        check_val("drop_idle.out",  bus1.m_out, 32'd0);

`ifdef MS8_MASTER_READY_EN
        // ready low for three strobe cycles, then high
        tick("ready", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick("ready", 1'b0, 1'b0);
        tick("ready", 1'b0, 1'b1);
        check_val("ready.cnt", 32'(cnt), 32'd2);
        check_val("ready.out", bus1.m_out, 32'd1);
        for (int i = 0; i < 4; i++) tick("ready_drain", 1'b0, 1'b1);
`endif

        // saturation of sent_count
        force dut1.r_sent_count = 16'hFFFE;
        @(negedge clk);
        release dut1.r_sent_count;
        m_cnt = 16'hFFFE;
        check_val("preload.cnt", 32'(cnt), 32'h0000FFFE);
        for (int i = 0; i < 8; i++) tick("sat", 1'b1, 1'b1);
        check_val("sat.cnt", 32'(cnt), 32'h0000FFFF);
        for (int i = 0; i < 4; i++) tick("sat_drain", 1'b0, 1'b1);

        // randomized enable (and ready) against the model
        for (int i = 0; i < 400; i++) begin
            tick("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end

        // wrap-around with GAP_CYCLES=0: continuous strobe
        enable2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("wrap0.out",  bus2.m_out, 32'h7FFFFFFF);
        check_val("wrap0.sync", 32'(bus2.m_out_sync), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check_val("wrap1.out",  bus2.m_out, 32'h80000000);
        check_val("wrap1.sync", 32'(bus2.m_out_sync), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check_val("wrap2.out",  bus2.m_out, 32'h80000001);
        check_val("wrap2.sync", 32'(bus2.m_out_sync), 32'd1);
        check_val("wrap2.cnt",  32'(cnt2), 32'd2);
        enable2 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
